muldiv: RTL and testbench
=========================

Name: muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- The ALU handles add/sub/logic/shift in one cycle. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU are issued here instead.
- The hazard unit stalls on busy and captures result on done.
- Radix-2 shift-add multiply and restoring divide, with a start/busy/done handshake and pipeline flush.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- flush  input  1  synchronous abort from branch/exception.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result, held until the next accepted start.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; busy=0, done=0, result=0.
  - Counter, accumulators and latched operands are cleared.
  - Reset mid-operation discards the op; no done is produced.
- Operand capture and sign handling:
  - In IDLE, start=1 and flush=0 latches a, b and funct3.
  - Signedness per op: MUL/MULH/DIV/REM signed×signed; MULHSU signed a, unsigned b; MULHU/DIVU/REMU unsigned.
  - Magnitudes are taken for signed negatives. Result sign is recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- FSM IDLE -> CALC:
  - Normal case; counter loads XLEN.
- FSM IDLE -> DONE (special cases, no iteration):
  - Divide-by-zero (b==0, DIV/DIVU/REM/REMU): quotient = all ones; remainder = a unmodified.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- FSM CALC:
  - One iteration per cycle, counter decrements.
  - Multiply: 2*XLEN-bit product register, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract, XLEN+1-bit partial remainder.
  - Counter==1 -> FIX.
- FSM FIX:
  - Apply two's-complement sign correction.
  - Select low product half (MUL), high half (MULH*), quotient or remainder.
  - Write result; -> DONE.
- FSM DONE:
  - done=1 for exactly one cycle; busy=0; -> IDLE.
- Latency (start accepted in cycle T):
  - Normal ops: done in cycle T+XLEN+2.
  - Special cases: done in cycle T+1.
  - busy=1 in cycles T+1 .. the cycle before done.
- Handshake and flush rules:
  - start while not IDLE is ignored; operands are not re-latched.
  - flush in CALC/FIX returns to IDLE next cycle: busy=0, no done, result unchanged.
  - flush in DONE suppresses nothing already registered; done still pulses.
  - start and flush in the same IDLE cycle: flush wins, start is ignored.
  - A start in the IDLE cycle after DONE is accepted (back-to-back ops).
- Width rules:
  - All internal arithmetic is unsigned on magnitudes; no overflow flag.
  - MULH family returns bits [2*XLEN-1:XLEN] of the signed-corrected product.

Decomposition:
- Shared defines header (alongside ALU_CTRL_* codes) holds:
  - MD_MUL..MD_REMU funct3 constants.
  - MD_IDLE/MD_CALC/MD_FIX/MD_DONE state encodings.
- One sub-module is natural: muldiv_iter, the per-cycle shift-add/shift-subtract datapath step (combinational).
- FSM, counter, sign handling and special-case detection stay in muldiv.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at T -> busy T+1..T+33, done at T+34, result=0xFFFFFFEB.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with done at T+1:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- flush at T+10 of a DIV -> busy=0 at T+11, no done, result holds the prior value; a new MUL started at T+11 completes correctly at T+45.
- Async reset asserted mid-CALC (between edges) -> busy/done/result=0 immediately. start with flush same cycle -> ignored. start while busy with different operands -> first op's result unaffected.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared op codes, FSM encodings and op-decode helpers for the
//                iterative RV32M multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // funct3 encodings of the M-extension ops handled by the unit
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // rs1 is treated as signed for every op except the fully unsigned ones
    function automatic logic md_signed_a(input logic [2:0] f);
        return (f != MD_MULHU) && (f != MD_DIVU) && (f != MD_REMU);
    endfunction

    // rs2 is signed only for the signed x signed ops
    function automatic logic md_signed_b(input logic [2:0] f);
        return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic md_is_div(input logic [2:0] f);
        return (f == MD_DIV) || (f == MD_DIVU) || (f == MD_REM) || (f == MD_REMU);
    endfunction

    function automatic logic md_is_rem(input logic [2:0] f);
        return (f == MD_REM) || (f == MD_REMU);
    endfunction

    function automatic logic md_is_signed_div(input logic [2:0] f);
        return (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : One radix-2 iteration step: shift-add for multiply and
//                restoring shift-subtract for divide. Purely combinational;
//                the caller decides which results to keep.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] prod_in,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   rem_in,
    input  logic [XLEN-1:0]   quo_in,
    input  logic [XLEN-1:0]   divisor,
    output logic [2*XLEN-1:0] prod_out,
    output logic [XLEN-1:0]   rem_out,
    output logic [XLEN-1:0]   quo_out
);

    logic [XLEN:0] addend;
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiplier bits sit in the low half and shift out as the product grows
    // into the high half; dividend bits shift out of quo into the partial
    // remainder while quotient bits shift in behind them.
    always_comb begin
        addend   = prod_in[0] ? {1'b0, mcand} : '0;
        sum      = {1'b0, prod_in[2*XLEN-1:XLEN]} + addend;
        prod_out = {sum, prod_in[XLEN-1:1]};

        shifted  = {rem_in, quo_in[XLEN-1]};
        diff     = shifted - {1'b0, divisor};
        if (diff[XLEN]) begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv
//  Description : Iterative RV32M multiply/divide unit. Works on operand
//                magnitudes, iterates one bit per cycle, then applies sign
//                correction. Start/busy/done handshake with pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN-1:0] prod_nx;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   in_mag_a;
    logic [XLEN-1:0]   in_mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_fix;

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .prod_in  (prod_q),
        .mcand    (mag_a_q),
        .rem_in   (rem_q),
        .quo_in   (quo_q),
        .divisor  (mag_b_q),
        .prod_out (prod_nx),
        .rem_out  (rem_nx),
        .quo_out  (quo_nx)
    );

    // Decode the incoming request and sign-correct / select the finished result
    always_comb begin
        sa       = md_signed_a(funct3) & a[XLEN-1];
        sb       = md_signed_b(funct3) & b[XLEN-1];
        in_mag_a = sa ? -a : a;
        in_mag_b = sb ? -b : b;

        div_zero = md_is_div(funct3) && (b == '0);
        div_ovf  = md_is_signed_div(funct3) && (a == MIN_NEG) && (b == '1);
        if (div_zero) begin
            special_res = md_is_rem(funct3) ? a : '1;
        end else begin
            special_res = md_is_rem(funct3) ? '0 : MIN_NEG;
        end

        prod_fix = neg_q ? -prod_q : prod_q;
        quo_fix  = neg_q ? -quo_q  : quo_q;
        rem_fix  = neg_q ? -rem_q  : rem_q;
        case (op_q)
            MD_MUL:                       res_fix = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res_fix = quo_fix;
            default:                      res_fix = rem_fix;
        endcase
    end

    // Next-state logic for the FSM, iteration registers and registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    op_d    = funct3;
                    mag_a_d = in_mag_a;
                    mag_b_d = in_mag_b;
                    neg_d   = md_is_rem(funct3) ? sa : (sa ^ sb);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        prod_d  = {{XLEN{1'b0}}, in_mag_b};
                        quo_d   = in_mag_a;
                        rem_d   = '0;
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    prod_d = prod_nx;
                    rem_d  = rem_nx;
                    quo_d  = quo_nx;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = MD_FIX;
                    end
                end
            end
            MD_FIX: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    result_d = res_fix;
                    state_d  = MD_DONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        busy_d = (state_d == MD_CALC) || (state_d == MD_FIX);
        done_d = (state_d == MD_DONE);
    end

    // State and datapath registers; reset discards any op in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : muldiv
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv
//  Description : Self-checking bench for muldiv. Expected results and
//                latencies are queued at issue and popped when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy_n;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    muldiv #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference behaviour of the RV32M ops
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, suy;
        logic [63:0]        ux, uy, p;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        suy = uy;
        case (f)
            3'b000: begin p = sx * sy;  return p[31:0];  end
            3'b001: begin p = sx * sy;  return p[63:32]; end
            3'b010: begin p = sx * suy; return p[63:32]; end
            3'b011: begin p = ux * uy;  return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(x) / $signed(y);
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] y, input logic [31:0] x);
        if (f[2] && y == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Drive one start pulse in cycle T and queue the expectation; returns in T+1
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input string nm);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; a = x; b = y;
        e.res    = r;
        e.lat    = exp_lat(f, y, x);
        e.busy_n = (e.lat == 1) ? 0 : e.lat - 1;
        e.name   = nm;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count cycles until done (0 if it never comes) and busy-high cycles before it
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int k = 1; k <= 50 && cyc == 0; k++) begin
            @(negedge clk);
            if (done) cyc = k;
            else if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        reset = 1'b0;
        last_res = '0;
    endtask

    task automatic test_mul();
        logic [2:0]  fs [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] xs [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ys [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] rs [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int cyc, bc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], xs[i], ys[i], rs[i], "mul");
            wait_done(cyc, bc);
            e = sb_q.pop_front();
            n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result[%0d]: got %h expected %h", e.name, i, result, e.res); end
            n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", e.name, i, cyc, e.lat); end
            n_tests++; if (bc != e.busy_n) begin n_fail++; $display("FAIL %s_busy[%0d]: got %0d expected %0d", e.name, i, bc, e.busy_n); end
            last_res = e.res;
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] xs [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] ys [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] rs [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int cyc, bc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], xs[i], ys[i], rs[i], "div");
            wait_done(cyc, bc);
            e = sb_q.pop_front();
            n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result[%0d]: got %h expected %h", e.name, i, result, e.res); end
            n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", e.name, i, cyc, e.lat); end
            n_tests++; if (bc != e.busy_n) begin n_fail++; $display("FAIL %s_busy[%0d]: got %0d expected %0d", e.name, i, bc, e.busy_n); end
            last_res = e.res;
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] xs [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] ys [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rs [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int cyc, bc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], xs[i], ys[i], rs[i], "special");
            wait_done(cyc, bc);
            e = sb_q.pop_front();
            n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result[%0d]: got %h expected %h", e.name, i, result, e.res); end
            n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", e.name, i, cyc, e.lat); end
            n_tests++; if (bc != e.busy_n) begin n_fail++; $display("FAIL %s_busy[%0d]: got %0d expected %0d", e.name, i, bc, e.busy_n); end
            last_res = e.res;
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        int          cyc, bc, dn;
        logic        busy_t10;
        exp_t        e;
        prior    = last_res;
        dn       = 0;
        busy_t10 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (i == 10) begin busy_t10 = busy; flush = 1'b1; end
        end
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b1; funct3 = 3'b000; a = 32'h0001_0003; b = 32'h0000_0105;
        e.res = model(3'b000, 32'h0001_0003, 32'h0000_0105);
        e.lat = 34; e.busy_n = 33; e.name = "flush_mul";
        sb_q.push_back(e);
        @(negedge clk);
        if (done) dn++;
        n_tests++; if (busy_t10 !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy_t10); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
        n_tests++; if (dn != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dn); end
        n_tests++; if (result !== prior) begin n_fail++; $display("FAIL flush_result_hold: got %h expected %h", result, prior); end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bc);
        e = sb_q.pop_front();
        n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result: got %h expected %h", e.name, result, e.res); end
        n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", e.name, cyc, e.lat); end
        n_tests++; if (bc != e.busy_n) begin n_fail++; $display("FAIL %s_busy: got %0d expected %0d", e.name, bc, e.busy_n); end
        last_res = e.res;
    endtask

    task automatic test_start_flush();
        logic [2:0]  fs [2] = '{3'b101, 3'b000};
        logic [31:0] xs [2] = '{32'd5, 32'd7};
        logic [31:0] ys [2] = '{32'd0, 32'd3};
        int nb, nd;
        for (int i = 0; i < 2; i++) begin
            nb = 0; nd = 0;
            @(posedge clk); #1;
            start = 1'b1; flush = 1'b1; funct3 = fs[i]; a = xs[i]; b = ys[i];
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (busy) nb++;
                if (done) nd++;
            end
            n_tests++; if (nb != 0) begin n_fail++; $display("FAIL start_flush_busy[%0d]: got %0d cycles expected 0", i, nb); end
            n_tests++; if (nd != 0) begin n_fail++; $display("FAIL start_flush_done[%0d]: got %0d pulses expected 0", i, nd); end
            n_tests++; if (result !== last_res) begin n_fail++; $display("FAIL start_flush_result[%0d]: got %h expected %h", i, result, last_res); end
        end
    endtask

    task automatic test_start_busy();
        int   cyc, bc;
        exp_t e;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "start_busy");
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bc);
        e = sb_q.pop_front();
        n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result: got %h expected %h", e.name, result, e.res); end
        n_tests++; if (cyc != e.lat - 5) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", e.name, cyc, e.lat - 5); end
        n_tests++; if (bc != e.busy_n - 5) begin n_fail++; $display("FAIL %s_busy: got %0d expected %0d", e.name, bc, e.busy_n - 5); end
        last_res = e.res;
    endtask

    task automatic test_async_reset();
        int nb, nd;
        nb = 0; nd = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", done); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL async_reset_result: got %h expected 0", result); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        n_tests++; if (nb != 0 || nd != 0) begin n_fail++; $display("FAIL async_reset_discard: got busy=%0d done=%0d expected 0/0", nb, nd); end
        last_res = '0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] x, y;
        int          cyc, bc;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(f, x, y, model(f, x, y), "b2b");
            wait_done(cyc, bc);
            e = sb_q.pop_front();
            n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL %s_result[%0d] f=%0d a=%h b=%h: got %h expected %h", e.name, i, f, x, y, result, e.res); end
            n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", e.name, i, cyc, e.lat); end
            n_tests++; if (bc != e.busy_n) begin n_fail++; $display("FAIL %s_busy[%0d]: got %0d expected %0d", e.name, i, bc, e.busy_n); end
            last_res = e.res;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_start_flush();
        test_start_busy();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_muldiv
`default_nettype wire
